// File: rtl/addsub_seq_unit.sv
// -----------------------------------------------------------------------------
// addsub_seq_unit
//   Multi-cycle two's-complement adder/subtractor for the processor datapath.
//   CHUNK bits are summed per cycle, and the carry ripples from one cycle to
//   the next.
//
//   Subtraction is formed as A + ~B + 1. B is inverted when the operands are
//   accepted, and the carry register is seeded with 'sub'.
//
//   Configuration macro:
//     ADDSUB_FLAGS_EN - when defined, carry_out/overflow/zero are computed and
//                       registered. When undefined, the flag ports are tied to
//                       0 and no flag logic is built.
//
//   Parameters:
//     WIDTH      operand/result width (default 32)
//     CHUNK      bits summed per cycle (default 8); WIDTH % CHUNK must be 0
//
//   Ports:
//     clock      rising-edge clock
//     reset_n    asynchronous active-low reset
//     in_valid   operands valid            (in)
//     in_ready   unit can accept operands  (out, high only in IDLE)
//     op_a/op_b  operands                  (in, WIDTH)
//     sub        1 = A - B, 0 = A + B      (in)
//     out_valid  result valid              (out, high only in DONE)
//     out_ready  consumer accepts result   (in)
//     result     sum/difference modulo 2^WIDTH (out, WIDTH)
//     carry_out  carry out of MSB; for subtract 1 = no borrow (out)
//     overflow   signed overflow           (out)
//     zero       result == 0               (out)
// -----------------------------------------------------------------------------
module addsub_seq_unit #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int SH_W   = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One chunk of the ripple adder: {carry, sum} = a + b + cin.
   function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] a,
                                                input logic [CHUNK-1:0] b,
                                                input logic             cin);
      return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   endfunction

   // Signed overflow: the operands have the same sign, but the sum has the other sign.
   function automatic logic signed_ovf(input logic a_msb,
                                       input logic b_msb,
                                       input logic r_msb);
      return (a_msb == b_msb) & (r_msb != a_msb);
   endfunction

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             carry_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;          // op_b already conditionally inverted
   logic [WIDTH-1:0] result_r;
   logic             in_ready_r;
   logic             out_valid_r;

   logic [SH_W-1:0]  sh_s;
   logic [CHUNK-1:0] chunk_a_s;
   logic [CHUNK-1:0] chunk_b_s;
   logic [CHUNK:0]   chunk_sum_s;
   logic [WIDTH-1:0] next_result_s;
   logic             last_chunk_s;

   // Select the current chunk, add it, and merge the sum into the result image.
   always_comb begin
      sh_s          = SH_W'(cnt_r) * SH_W'(CHUNK);
      chunk_a_s     = CHUNK'(a_r >> sh_s);
      chunk_b_s     = CHUNK'(b_r >> sh_s);
      chunk_sum_s   = chunk_add(chunk_a_s, chunk_b_s, carry_r);
      next_result_s = (result_r & ~(CHUNK_MASK << sh_s))
                    | (WIDTH'(chunk_sum_s[CHUNK-1:0]) << sh_s);
      last_chunk_s  = (cnt_r == LAST_CNT);
   end

   // Main FSM: IDLE accepts operands, RUN adds one chunk per cycle, DONE holds the result.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         carry_r     <= 1'b0;
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         result_r    <= {WIDTH{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  a_r        <= op_a;
                  b_r        <= op_b ^ {WIDTH{sub}};
                  carry_r    <= sub;
                  cnt_r      <= {CNT_W{1'b0}};
                  result_r   <= {WIDTH{1'b0}};
                  in_ready_r <= 1'b0;
                  state_r    <= ST_RUN;
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            ST_RUN: begin
               result_r <= next_result_s;
               carry_r  <= chunk_sum_s[CHUNK];
               if (last_chunk_s) begin
                  state_r     <= ST_DONE;
                  out_valid_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_DONE: begin
               // The result and flags are frozen here until the consumer takes them.
               if (out_ready) begin
                  state_r     <= ST_IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result    = result_r;

`ifdef ADDSUB_FLAGS_EN
   logic carry_out_r;
   logic overflow_r;
   logic zero_r;

   // Flag registers: cleared on accept and captured from the final chunk.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         carry_out_r <= 1'b0;
         overflow_r  <= 1'b0;
         zero_r      <= 1'b0;
      end else if ((state_r == ST_IDLE) && in_valid) begin
         carry_out_r <= 1'b0;
         overflow_r  <= 1'b0;
         zero_r      <= 1'b0;
      end else if ((state_r == ST_RUN) && last_chunk_s) begin
         carry_out_r <= chunk_sum_s[CHUNK];
         overflow_r  <= signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], next_result_s[WIDTH-1]);
         zero_r      <= ~|next_result_s;
      end else begin
         carry_out_r <= carry_out_r;
         overflow_r  <= overflow_r;
         zero_r      <= zero_r;
      end
   end

   assign carry_out = carry_out_r;
   assign overflow  = overflow_r;
   assign zero      = zero_r;
`else
   assign carry_out = 1'b0;
   assign overflow  = 1'b0;
   assign zero      = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_addsub_seq_unit
//   Directed bench for addsub_seq_unit. It uses two instances:
//     u_dut   : WIDTH=32, CHUNK=8  (latency 4)
//     u_dut32 : WIDTH=32, CHUNK=32 (latency 1)
//   Expected values are hand-computed constants.
//   Flag expectations follow ADDSUB_FLAGS_EN. When the macro is undefined,
//   the expected flag values are 0.
// -----------------------------------------------------------------------------
module tb_addsub_seq_unit;

`ifdef ADDSUB_FLAGS_EN
   localparam bit FLAGS_ON = 1'b1;
`else
   localparam bit FLAGS_ON = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid, in_valid32;
   logic        out_ready, out_ready32;
   logic [31:0] op_a, op_b;
   logic        sub;

   logic        in_ready, out_valid, carry_out, overflow, zero;
   logic [31:0] result;
   logic        in_ready32, out_valid32, carry_out32, overflow32, zero32;
   logic [31:0] result32;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   addsub_seq_unit #(.WIDTH(32), .CHUNK(8)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
   );

   addsub_seq_unit #(.WIDTH(32), .CHUNK(32)) u_dut32 (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid32), .in_ready(in_ready32),
      .op_a(op_a), .op_b(op_b), .sub(sub),
      .out_valid(out_valid32), .out_ready(out_ready32),
      .result(result32), .carry_out(carry_out32), .overflow(overflow32), .zero(zero32)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, wait for the result within a bound, check it, and then complete the handshake.
   task automatic run_op(input string tag, input bit wide,
                         input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int lat, input logic [31:0] er,
                         input bit ec, input bit ev, input bit ez, input bit noise);
      int cyc;
      chk({tag, " in_ready_idle"}, 32'(wide ? in_ready32 : in_ready), 32'd1);
      op_a = a; op_b = b; sub = s;
      if (wide) in_valid32 = 1'b1; else in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0; in_valid32 = 1'b0;
      chk({tag, " in_ready_run"}, 32'(wide ? in_ready32 : in_ready), 32'd0);
      // Operands change after acceptance; an optional in_valid pulse occurs during RUN.
      op_a = 32'hDEADBEEF; op_b = 32'h0BADF00D; sub = ~s;
      if (noise) begin
         if (wide) in_valid32 = 1'b1; else in_valid = 1'b1;
      end
      cyc = 0;
      while (!(wide ? out_valid32 : out_valid) && cyc < 20) begin
         @(posedge clock); #1;
         cyc++;
         in_valid = 1'b0; in_valid32 = 1'b0;
      end
      chk({tag, " latency"}, 32'(cyc), 32'(lat));
      chk({tag, " result"}, wide ? result32 : result, er);
      chk({tag, " carry"}, 32'(wide ? carry_out32 : carry_out), 32'(ec & FLAGS_ON));
      chk({tag, " ovf"}, 32'(wide ? overflow32 : overflow), 32'(ev & FLAGS_ON));
      chk({tag, " zero"}, 32'(wide ? zero32 : zero), 32'(ez & FLAGS_ON));
      if (wide) out_ready32 = 1'b1; else out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0; out_ready32 = 1'b0;
      chk({tag, " out_valid_drop"}, 32'(wide ? out_valid32 : out_valid), 32'd0);
      chk({tag, " in_ready_back"}, 32'(wide ? in_ready32 : in_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      reset_n = 1'b0; in_valid = 1'b0; in_valid32 = 1'b0;
      out_ready = 1'b0; out_ready32 = 1'b0;
      op_a = 32'd0; op_b = 32'd0; sub = 1'b0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst result", result, 32'd0);
      chk("rst carry", 32'(carry_out), 32'd0);
      chk("rst ovf", 32'(overflow), 32'd0);
      chk("rst zero", 32'(zero), 32'd0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Tests 1-4: CHUNK=8, latency 4
      run_op("t1 5+3",       1'b0, 32'd5,        32'd3, 1'b0, 4, 32'd8,        1'b0, 1'b0, 1'b0, 1'b1);
      run_op("t2 3-5",       1'b0, 32'd3,        32'd5, 1'b1, 4, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op("t2 eq-sub",    1'b0, 32'h1234,     32'h1234, 1'b1, 4, 32'd0,     1'b1, 1'b0, 1'b1, 1'b0);
      run_op("t3 pos-ovf",   1'b0, 32'h7FFFFFFF, 32'd1, 1'b0, 4, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
      run_op("t3 neg-ovf",   1'b0, 32'h80000000, 32'd1, 1'b1, 4, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
      run_op("t4 ripple",    1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, 4, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0);

      // Test 5: stall in DONE while in_valid pulses with new operands
      op_a = 32'h100; op_b = 32'h23; sub = 1'b0; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clock); #1;
         cyc++;
      end
      chk("t5 latency", 32'(cyc), 32'd4);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'(i & 1); op_a = 32'(i) * 32'h1111; op_b = 32'(i); sub = 1'(i >> 1);
         @(posedge clock); #1;
         chk("t5 stall result", result, 32'h123);
         chk("t5 stall in_ready", 32'(in_ready), 32'd0);
         chk("t5 stall out_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      chk("t5 release in_ready", 32'(in_ready), 32'd1);
      chk("t5 release out_valid", 32'(out_valid), 32'd0);
      chk("t5 release result", result, 32'h123);

      // Test 6: async reset during RUN chunk 2
      op_a = 32'h11223344; op_b = 32'h01010101; sub = 1'b0; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("t6 partial result", result, 32'h00003445);
      chk("t6 run in_ready", 32'(in_ready), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      chk("t6 rst in_ready", 32'(in_ready), 32'd1);
      chk("t6 rst out_valid", 32'(out_valid), 32'd0);
      chk("t6 rst result", result, 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      run_op("t6 after rst", 1'b0, 32'h10, 32'h1, 1'b1, 4, 32'hF, 1'b1, 1'b0, 1'b0, 1'b0);

      // Tests 1-3 repeated with CHUNK=32, latency 1
      run_op("w1 5+3",       1'b1, 32'd5,        32'd3, 1'b0, 1, 32'd8,        1'b0, 1'b0, 1'b0, 1'b1);
      run_op("w2 3-5",       1'b1, 32'd3,        32'd5, 1'b1, 1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op("w2 eq-sub",    1'b1, 32'h1234,     32'h1234, 1'b1, 1, 32'd0,     1'b1, 1'b0, 1'b1, 1'b0);
      run_op("w3 pos-ovf",   1'b1, 32'h7FFFFFFF, 32'd1, 1'b0, 1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
      run_op("w3 neg-ovf",   1'b1, 32'h80000000, 32'd1, 1'b1, 1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
